// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame edge indices and parity helper.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_INHIBIT  = 3'd1;
   localparam logic [2:0] S_REQ      = 3'd2;
   localparam logic [2:0] S_BITS     = 3'd3;
   localparam logic [2:0] S_ACK      = 3'd4;
   localparam logic [2:0] S_WAITIDLE = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = S_IDLE,
      ST_INHIBIT  = S_INHIBIT,
      ST_REQ      = S_REQ,
      ST_BITS     = S_BITS,
      ST_ACK      = S_ACK,
      ST_WAITIDLE = S_WAITIDLE
   } state_t;

   // Device falling-edge numbers within a host-to-device frame (edge 1 = start bit clocked)
   localparam logic [3:0] EDGE_FIRST_BIT = 4'd2;
   localparam logic [3:0] EDGE_PARITY    = 4'd10;
   localparam logic [3:0] EDGE_STOP      = 4'd11;
   localparam logic [3:0] EDGE_ACK       = 4'd12;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus clock falling-edge detect.
// Lines reset to their idle-high value so reset never produces a spurious edge.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic [1:0] stage1_reg;
   logic [1:0] stage2_reg;
   logic       clk_prev_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stage1_reg   <= 2'b11;
         stage2_reg   <= 2'b11;
         clk_prev_reg <= 1'b1;
      end else begin
         stage1_reg   <= {ps2_data, ps2_clk};
         stage2_reg   <= stage1_reg;
         clk_prev_reg <= stage2_reg[0];
      end
   end

   assign clk_sync  = stage2_reg[0];
   assign data_sync = stage2_reg[1];
   assign clk_fall  = clk_prev_reg & ~stage2_reg[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out data/parity/stop
// on device falling edges, check the device ACK, with a per-edge timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t             state_reg, state_next;
   logic [7:0]         byte_reg, byte_next;
   logic               parity_reg, parity_next;
   logic [3:0]         edge_reg, edge_next;
   logic [INH_W-1:0]   inh_reg, inh_next;
   logic [TMO_W-1:0]   tmo_reg, tmo_next;
   logic               clk_oe_reg, clk_oe_next;
   logic               data_oe_reg, data_oe_next;
   logic               done_reg, done_next;
   logic               err_reg, err_next;
   logic               ready_reg, ready_next;
   logic               clk_sync, data_sync, clk_fall;
   logic [3:0]         edge_n;
   logic               waiting;

   ps2_sync_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk_in),
      .ps2_data  (ps2_data_in),
      .clk_sync  (clk_sync),
      .data_sync (data_sync),
      .clk_fall  (clk_fall)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         byte_reg    <= '0;
         parity_reg  <= 1'b0;
         edge_reg    <= '0;
         inh_reg     <= '0;
         tmo_reg     <= '0;
         clk_oe_reg  <= 1'b0;
         data_oe_reg <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         ready_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         byte_reg    <= byte_next;
         parity_reg  <= parity_next;
         edge_reg    <= edge_next;
         inh_reg     <= inh_next;
         tmo_reg     <= tmo_next;
         clk_oe_reg  <= clk_oe_next;
         data_oe_reg <= data_oe_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         ready_reg   <= ready_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      byte_next    = byte_reg;
      parity_next  = parity_reg;
      edge_next    = edge_reg;
      inh_next     = inh_reg;
      tmo_next     = tmo_reg;
      clk_oe_next  = clk_oe_reg;
      data_oe_next = data_oe_reg;
      done_next    = 1'b0;
      err_next     = 1'b0;
      edge_n       = edge_reg + 4'd1;
      waiting      = state_reg inside {ST_REQ, ST_BITS, ST_ACK, ST_WAITIDLE};

      if (waiting)
         tmo_next = clk_fall ? '0 : tmo_reg + 1'b1;

      case (state_reg)
         ST_IDLE: begin
            clk_oe_next  = 1'b0;
            data_oe_next = 1'b0;
            if (tx_valid && ready_reg) begin
               byte_next    = tx_data;
               parity_next  = odd_parity(tx_data);
               inh_next     = '0;
               clk_oe_next  = 1'b1;
               data_oe_next = (INHIBIT_CYCLES == 1);
               state_next   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_reg == INH_LAST) begin
               clk_oe_next  = 1'b0;
               data_oe_next = 1'b1;
               edge_next    = '0;
               state_next   = ST_REQ;
            end else begin
               inh_next     = inh_reg + 1'b1;
               clk_oe_next  = 1'b1;
               data_oe_next = (inh_reg == INH_PRE);
            end
         end
         ST_REQ: begin
            if (clk_fall) begin
               edge_next  = 4'd1;
               state_next = ST_BITS;
            end
         end
         ST_BITS: begin
            if (clk_fall) begin
               edge_next = edge_n;
               if (edge_n == EDGE_STOP) begin
                  data_oe_next = 1'b0;
                  state_next   = ST_ACK;
               end else if (edge_n == EDGE_PARITY) begin
                  data_oe_next = ~parity_reg;
               end else begin
                  data_oe_next = ~byte_reg[3'(edge_n - EDGE_FIRST_BIT)];
               end
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               edge_next = EDGE_ACK;
               if (!data_sync) begin
                  state_next = ST_WAITIDLE;
               end else begin
                  err_next   = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         ST_WAITIDLE: begin
            if (clk_sync && data_sync) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // A device that stops clocking must not hold the bus forever
      if (waiting && !clk_fall && !done_next && tmo_reg == TMO_LAST) begin
         clk_oe_next  = 1'b0;
         data_oe_next = 1'b0;
         err_next     = 1'b1;
         state_next   = ST_IDLE;
      end

      if (state_next != state_reg)
         tmo_next = '0;

      ready_next = (state_next == ST_IDLE) && !done_next && !err_next;
   end

   assign tx_ready    = ready_reg;
   assign tx_done     = done_reg;
   assign tx_err      = err_reg;
   assign ps2_clk_oe  = clk_oe_reg;
   assign ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// captures each sampled bit; frames, pulses, inhibit length and timeouts are checked.
module tb_ps2_host_tx;

   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic [10:0] frame;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int clk_run = 0, data_at = 0, last_clk_run = 0, last_data_at = 0;
   int req_at = 0, err_at = 0;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (5000),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_err) begin
         err_cnt++;
         err_at = cyc;
      end
      if (tx_done && tx_err) both_cnt++;
      if (ps2_clk_oe) begin
         clk_run++;
         if (ps2_data_oe && data_at == 0) data_at = clk_run;
      end else if (clk_run != 0) begin
         last_clk_run = clk_run;
         last_data_at = data_at;
         req_at       = cyc;
         clk_run      = 0;
         data_at      = 0;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog cycles=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      @(posedge clk);
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_value("ready_before_send", 32'(tx_ready), 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_value(tag, 32'(tx_ready), 32'd1);
   endtask

   // Device side: clocks `edges` falling edges, samples the line at each rising edge;
   // edge 12 drives data low when ack is set.
   task automatic dev_run(input int edges, input bit ack, output logic [10:0] fr);
      int n = 0;
      fr = '0;
      @(negedge clk);
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_value("req_seen", 32'(n < 20000), 32'd1);
      if (n >= 20000) return;
      repeat (10) @(negedge clk);
      for (int e = 1; e <= edges && e <= 11; e++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         fr[e-1] = ps2_data_in;
         repeat (HALF) @(negedge clk);
      end
      if (edges >= 12) begin
         dev_data = ack ? 1'b0 : 1'b1;
         repeat (5) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_data = 1'b1;
      end
   endtask

   task automatic report(input string name, input logic [10:0] fr);
      $display("[TB] txn %s frame=0x%03h done=%0d err=%0d", name, fr, done_cnt, err_cnt);
   endtask

   initial begin
      // reset state
      repeat (5) @(negedge clk);
      check_value("rst_ready", 32'(tx_ready), 32'd0);
      check_value("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check_value("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check_value("rst_done_err", 32'({tx_done, tx_err}), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_value("rst_release_ready", 32'(tx_ready), 32'd1);

      // 0xED with ACK
      clear_counts();
      send(8'hED);
      dev_run(12, 1'b1, frame);
      wait_ready("ed_ready");
      report("0xED", frame);
      check_value("ed_frame", 32'(frame), 32'h7DA);
      check_value("ed_done", 32'(done_cnt), 32'd1);
      check_value("ed_err", 32'(err_cnt), 32'd0);
      check_value("ed_inhibit_len", 32'(last_clk_run), 32'd5000);
      check_value("ed_data_oe_at", 32'(last_data_at), 32'd5000);
      check_value("ed_lines_idle", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

      // 0xF4: parity 0
      clear_counts();
      send(8'hF4);
      dev_run(12, 1'b1, frame);
      wait_ready("f4_ready");
      report("0xF4", frame);
      check_value("f4_parity", 32'(frame[9]), 32'd0);
      check_value("f4_frame", 32'(frame), 32'h5E8);
      check_value("f4_done", 32'(done_cnt), 32'd1);

      // 0x00: parity 1
      clear_counts();
      send(8'h00);
      dev_run(12, 1'b1, frame);
      wait_ready("z_ready");
      report("0x00", frame);
      check_value("z_parity", 32'(frame[9]), 32'd1);
      check_value("z_frame", 32'(frame), 32'h600);
      check_value("z_done", 32'(done_cnt), 32'd1);

      // NACK at edge 12
      clear_counts();
      send(8'hED);
      dev_run(12, 1'b0, frame);
      wait_ready("nack_ready");
      report("0xED-nack", frame);
      check_value("nack_err", 32'(err_cnt), 32'd1);
      check_value("nack_done", 32'(done_cnt), 32'd0);
      check_value("nack_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

      // Timeout: device never clocks
      clear_counts();
      send(8'h12);
      begin
         int n = 0;
         while (err_cnt == 0 && n < 8000) begin
            @(negedge clk);
            n++;
         end
      end
      wait_ready("tmo_ready");
      report("0x12-timeout", 11'h000);
      check_value("tmo_err", 32'(err_cnt), 32'd1);
      check_value("tmo_done", 32'(done_cnt), 32'd0);
      check_value("tmo_latency", 32'(err_at - req_at), 32'd1000);
      check_value("tmo_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

      // Reset during inhibit
      clear_counts();
      send(8'h55);
      repeat (100) @(negedge clk);
      check_value("inh_clk_oe_pre", 32'(ps2_clk_oe), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check_value("inh_rst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      check_value("inh_rst_ready", 32'(tx_ready), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_value("inh_rst_ready_after", 32'(tx_ready), 32'd1);
      report("0x55-reset", 11'h000);

      // Reset after edge 5, then a clean 0xED
      clear_counts();
      send(8'hED);
      dev_run(5, 1'b1, frame);
      reset = 1'b0;
      @(negedge clk);
      check_value("e5_rst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      repeat (3) @(negedge clk);
      check_value("e5_rst_pulses", 32'({tx_done, tx_err, tx_ready}), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_value("e5_ready_after", 32'(tx_ready), 32'd1);
      report("0xED-reset-e5", frame);
      clear_counts();
      send(8'hED);
      dev_run(12, 1'b1, frame);
      wait_ready("e5_next_ready");
      report("0xED-after-reset", frame);
      check_value("e5_next_frame", 32'(frame), 32'h7DA);
      check_value("e5_next_done", 32'(done_cnt), 32'd1);

      // tx_valid toggled with 0xAA during a 0xED transfer
      clear_counts();
      send(8'hED);
      fork
         dev_run(12, 1'b1, frame);
         begin
            repeat (5200) begin
               @(negedge clk);
               tx_valid = ~tx_valid;
               tx_data  = 8'hAA;
            end
            tx_valid = 1'b0;
         end
      join
      wait_ready("tog_ready");
      repeat (100) @(negedge clk);
      report("0xED-toggle", frame);
      check_value("tog_frame", 32'(frame), 32'h7DA);
      check_value("tog_done", 32'(done_cnt), 32'd1);
      check_value("tog_err", 32'(err_cnt), 32'd0);
      check_value("tog_no_restart", 32'({ps2_clk_oe, tx_ready}), 32'd1);

      check_value("never_both", 32'(both_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
